// File: rtl/dp_ram_pkg.sv
// Shared types and default geometry for the dp_ram_param block.
// Optional parity storage is selected with DP_RAM_PARITY_EN.
package dp_ram_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage : dp_ram_pkg

// File: rtl/dp_ram_param_if.sv
// Request/response bus of dp_ram_param; master drives requests, slave returns read data.
// parity_err exists only when DP_RAM_PARITY_EN is defined.
interface dp_ram_param_if
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              init_busy;
  logic              addr_err;
`ifdef DP_RAM_PARITY_EN
  logic              parity_err;
`endif

  modport master (
    output wr_en, wr_addr, data_in, rd_en, rd_addr,
    input  data_out, rd_valid, init_busy, addr_err
`ifdef DP_RAM_PARITY_EN
    , parity_err
`endif
  );

  modport slave (
    input  wr_en, wr_addr, data_in, rd_en, rd_addr,
    output data_out, rd_valid, init_busy, addr_err
`ifdef DP_RAM_PARITY_EN
    , parity_err
`endif
  );

endinterface : dp_ram_param_if

// File: rtl/dp_ram_core.sv
// Plain storage array: one synchronous write port, one combinational read port.
// Callers guarantee addresses are below DEPTH before enabling a write or using read data.
module dp_ram_core #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[IDX_W'(waddr)] <= wdata;
    end
  end

  assign rdata_c = mem[IDX_W'(raddr)];

endmodule : dp_ram_core

// File: rtl/dp_ram_param.sv
// Parameterised RAM with power-up clear sweep, write-first bypass and address range checks.
// Define DP_RAM_PARITY_EN to store an even-parity bit per word and report parity_err on reads.
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  dp_ram_param_if.slave  bus
);

`ifdef DP_RAM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned MEM_W = DATA_W + PAR_W;
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  DEPTH_L = CMP_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;

  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [MEM_W-1:0]  core_wdata;
  logic [MEM_W-1:0]  core_rdata;
  logic [MEM_W-1:0]  wr_word;

  logic              ready_c;
  logic              wr_in_c, rd_in_c;
  logic              wr_ok_c, rd_ok_c;
  logic              bypass_c;
  logic              err_c;

  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              init_busy_q;
  logic              addr_err_q;

  // Request qualification: only READY requests count, and only in-range ones touch memory.
  assign ready_c  = (state_q == ST_READY);
  assign wr_in_c  = ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_in_c  = ({1'b0, bus.rd_addr} < DEPTH_L);
  assign wr_ok_c  = ready_c & bus.wr_en & wr_in_c;
  assign rd_ok_c  = ready_c & bus.rd_en & rd_in_c;
  assign bypass_c = wr_ok_c & rd_ok_c & (bus.wr_addr == bus.rd_addr);
  assign err_c    = ready_c & ((bus.wr_en & ~wr_in_c) | (bus.rd_en & ~rd_in_c));

`ifdef DP_RAM_PARITY_EN
  assign wr_word = {^bus.data_in, bus.data_in};
`else
  assign wr_word = bus.data_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // INIT owns the write port to clear one word per cycle; READY hands it to requests.
  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    core_we    = 1'b0;
    core_waddr = bus.wr_addr;
    core_wdata = wr_word;
    case (state_q)
      ST_INIT: begin
        core_we    = 1'b1;
        core_waddr = clr_q;
        core_wdata = '0;
        if (clr_q == LAST_L) begin
          state_d = ST_READY;
        end else begin
          clr_d = clr_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        core_we = wr_ok_c;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  dp_ram_core #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .we      (core_we),
    .waddr   (core_waddr),
    .wdata   (core_wdata),
    .raddr   (bus.rd_addr),
    .rdata_c (core_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      init_busy_q <= 1'b1;
      addr_err_q  <= 1'b0;
    end else begin
      rd_valid_q  <= rd_ok_c;
      init_busy_q <= (state_d == ST_INIT);
      addr_err_q  <= err_c;
      if (rd_ok_c) begin
        data_out_q <= bypass_c ? bus.data_in : core_rdata[DATA_W-1:0];
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_busy = init_busy_q;
  assign bus.addr_err  = addr_err_q;

`ifdef DP_RAM_PARITY_EN
  logic parity_err_q;

  // Bypassed reads use fresh data_in, so they can never carry a stored-parity fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= rd_ok_c & ~bypass_c & (^core_rdata);
    end
  end

  assign bus.parity_err = parity_err_q;
`endif

endmodule : dp_ram_param

// File: tb/tb_dp_ram_param.sv
// Self-checking bench for dp_ram_param (DATA_W=8, ADDR_W=8, DEPTH=200) with a read scoreboard.
// Parity scenario is compiled only when DP_RAM_PARITY_EN is defined.
module tb_dp_ram_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 200;

  logic clk = 1'b0;
  logic rst;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] last_rd;
  logic [DATA_W-1:0] exp_v;

  dp_ram_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dp_ram_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
  endtask

  // Drive one cycle's requests; the model applies the write first so same-address reads see new data.
  task automatic drive(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic re, input logic [7:0] ra);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.data_in = wd;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    if (we && wa < DEPTH) model[wa] = wd;
    if (re && ra < DEPTH) exp_q.push_back(model[ra]);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle_inputs();
    exp_q.delete();
    // Requests held during reset and sweep must be ignored.
    bus.wr_en = 1'b1; bus.wr_addr = 8'd5; bus.data_in = 8'hFF;
    bus.rd_en = 1'b1; bus.rd_addr = 8'd10;
    repeat (3) step();
    n_cmp++;
    if (bus.init_busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.addr_err !== 1'b0 || bus.data_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: busy=%b valid=%b err=%b dout=%h, want 1 0 0 00",
               bus.init_busy, bus.rd_valid, bus.addr_err, bus.data_out);
    end
    rst = 1'b0;
    n = 0;
    while (bus.init_busy === 1'b1 && n < 1000) begin
      n++;
      if (n == 100) bus.rd_addr = 8'd250;
      step();
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.addr_err !== 1'b0) begin
        n_err++;
        $display("FAIL init_ignore: cycle %0d valid=%b err=%b, want 0 0", n, bus.rd_valid, bus.addr_err);
      end
    end
    idle_inputs();
    n_cmp++;
    if (n != 200) begin
      n_err++;
      $display("FAIL init_len: init_busy high %0d cycles, want 200", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_init_zero();
    logic [7:0] addrs [4];
    addrs[0] = 8'd0; addrs[1] = 8'd5; addrs[2] = 8'd100; addrs[3] = 8'd199;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd0, 8'd0, 1'b1, addrs[i]);
      step();
      exp_v = exp_q.pop_front();
      last_rd = exp_v;
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== exp_v) begin
        n_err++;
        $display("FAIL init_zero[%0d]: valid=%b dout=%h, want 1 %h", addrs[i], bus.rd_valid, bus.data_out, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    drive(1'b1, 8'h10, 8'hA5, 1'b0, 8'h00);
    step();
    n_cmp++;
    if (bus.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wr_only_valid: valid=%b, want 0", bus.rd_valid);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h10);
    step();
    idle_inputs();
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_err++;
      $display("FAIL wr_rd: valid=%b dout=%h, want 1 %h", bus.rd_valid, bus.data_out, exp_v);
    end
    step();
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.data_out !== last_rd) begin
      n_err++;
      $display("FAIL hold: valid=%b dout=%h, want 0 %h", bus.rd_valid, bus.data_out, last_rd);
    end
  endtask

  task automatic test_write_first();
    logic [7:0] wa [4], wd [4], ra [4];
    logic       we [4];
    we[0] = 1'b0; wa[0] = 8'h00; wd[0] = 8'h00; ra[0] = 8'h20;
    we[1] = 1'b1; wa[1] = 8'h20; wd[1] = 8'h3C; ra[1] = 8'h20;
    we[2] = 1'b1; wa[2] = 8'h30; wd[2] = 8'h55; ra[2] = 8'h10;
    we[3] = 1'b0; wa[3] = 8'h00; wd[3] = 8'h00; ra[3] = 8'h30;
    for (int i = 0; i < 4; i++) begin
      drive(we[i], wa[i], wd[i], 1'b1, ra[i]);
      step();
      exp_v = exp_q.pop_front();
      last_rd = exp_v;
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== exp_v) begin
        n_err++;
        $display("FAIL wr_first[%0d]: valid=%b dout=%h, want 1 %h", i, bus.rd_valid, bus.data_out, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 8'd200, 8'hFF, 1'b1, 8'd250);
    step();
    idle_inputs();
    n_cmp++;
    if (bus.addr_err !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_out !== last_rd) begin
      n_err++;
      $display("FAIL oor_both: err=%b valid=%b dout=%h, want 1 0 %h", bus.addr_err, bus.rd_valid, bus.data_out, last_rd);
    end
    step();
    n_cmp++;
    if (bus.addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL oor_pulse: err=%b, want 0", bus.addr_err);
    end
    drive(1'b1, 8'd220, 8'h99, 1'b1, 8'h10);
    step();
    idle_inputs();
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_cmp++;
    if (bus.addr_err !== 1'b1 || bus.rd_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_err++;
      $display("FAIL oor_wr_rd_ok: err=%b valid=%b dout=%h, want 1 1 %h", bus.addr_err, bus.rd_valid, bus.data_out, exp_v);
    end
    drive(1'b0, 8'd0, 8'd0, 1'b1, 8'd199);
    step();
    idle_inputs();
    exp_v = exp_q.pop_front();
    last_rd = exp_v;
    n_cmp++;
    if (bus.addr_err !== 1'b0 || bus.rd_valid !== 1'b1 || bus.data_out !== exp_v) begin
      n_err++;
      $display("FAIL last_word: err=%b valid=%b dout=%h, want 0 1 %h", bus.addr_err, bus.rd_valid, bus.data_out, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      if (i < 40) drive(1'b1, 8'(40 + i), 8'($urandom_range(255)), 1'b1, 8'(i));
      else        drive(1'b0, 8'd0, 8'd0, 1'b1, 8'(i));
      step();
      exp_v = exp_q.pop_front();
      last_rd = exp_v;
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== exp_v) begin
        n_err++;
        $display("FAIL b2b[%0d]: valid=%b dout=%h, want 1 %h", i, bus.rd_valid, bus.data_out, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midsweep();
    int n;
    drive(1'b1, 8'd150, 8'h77, 1'b0, 8'd0);
    step();
    // Read issued in the same cycle as reset must never produce a result.
    drive(1'b0, 8'd0, 8'd0, 1'b1, 8'd150);
    exp_q.delete();
    rst = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.init_busy !== 1'b1 || bus.data_out !== 8'h00) begin
      n_err++;
      $display("FAIL rst_discard: valid=%b busy=%b dout=%h, want 0 1 00", bus.rd_valid, bus.init_busy, bus.data_out);
    end
    rst = 1'b0;
    repeat (50) step();
    n_cmp++;
    if (bus.init_busy !== 1'b1) begin
      n_err++;
      $display("FAIL midsweep_busy: busy=%b, want 1", bus.init_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    bus.wr_en = 1'b1; bus.wr_addr = 8'd150; bus.data_in = 8'hEE;
    while (bus.init_busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    idle_inputs();
    n_cmp++;
    if (n != 200) begin
      n_err++;
      $display("FAIL restart_len: init_busy high %0d cycles, want 200", n);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'd0, 8'd0, 1'b1, (i == 0) ? 8'd150 : 8'h10);
      step();
      exp_v = exp_q.pop_front();
      last_rd = exp_v;
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== exp_v) begin
        n_err++;
        $display("FAIL cleared[%0d]: valid=%b dout=%h, want 1 %h", i, bus.rd_valid, bus.data_out, exp_v);
      end
    end
    idle_inputs();
  endtask

`ifdef DP_RAM_PARITY_EN
  task automatic test_parity();
    drive(1'b1, 8'h05, 8'h07, 1'b0, 8'h00);
    step();
    idle_inputs();
    u_dut.u_core.mem[5][DATA_W] = ~u_dut.u_core.mem[5][DATA_W];
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'd0, 8'd0, 1'b1, (i == 0) ? 8'h05 : 8'h06);
      step();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.data_out !== exp_v || bus.parity_err !== (i == 0)) begin
        n_err++;
        $display("FAIL parity[%0d]: valid=%b dout=%h perr=%b, want 1 %h %b",
                 i, bus.rd_valid, bus.data_out, bus.parity_err, exp_v, (i == 0));
      end
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_init_zero();
    test_write_read();
    test_write_first();
    test_out_of_range();
    test_back_to_back();
`ifdef DP_RAM_PARITY_EN
    test_parity();
`endif
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dp_ram_param

// File: doc/dp_ram_param.md
DP_RAM_PARAM -- requirements
Module: dp_ram_param

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width in bits.
REQ-003 Parameter DEPTH, default 256: number of words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  write request this cycle.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 rd_en  input  1  read request this cycle.
REQ-011 rd_addr  input  ADDR_W  read address.
REQ-012 data_out  output  DATA_W  registered read data.
REQ-013 rd_valid  output  1  data_out carries a new read result this cycle.
REQ-014 init_busy  output  1  memory clear sweep in progress; requests ignored.
REQ-015 addr_err  output  1  one-cycle pulse: previous-cycle request had an address >= DEPTH.

Function
REQ-016 The block SHALL have a two-state FSM: INIT and READY.
REQ-017 INIT: a clear counter runs 0..DEPTH-1, writing zero to one word per cycle; after writing word DEPTH-1 the FSM SHALL move to READY on the next edge (init_busy high for exactly DEPTH cycles after rst deasserts).
REQ-018 In INIT, wr_en and rd_en SHALL be ignored: no memory update, rd_valid=0, addr_err=0.
REQ-019 In READY, wr_en with wr_addr < DEPTH SHALL write data_in at the rising edge.
REQ-020 In READY, rd_en with rd_addr < DEPTH at edge N SHALL produce data_out and rd_valid=1 after edge N+1 (latency 1); otherwise rd_valid=0.
REQ-021 data_out SHALL hold its last value when rd_valid=0.
REQ-022 Same-cycle write and read to the same in-range address SHALL be write-first: data_out returns that cycle's data_in.
REQ-023 Write and read to different addresses in the same cycle SHALL both complete independently.
REQ-024 Out-of-range write SHALL be dropped; out-of-range read SHALL give rd_valid=0 and leave data_out unchanged; either SHALL pulse addr_err one cycle later.
REQ-025 Back-to-back reads every cycle SHALL give rd_valid every cycle, no bubbles.

Reset
REQ-026 On rst: FSM=INIT, clear counter=0, data_out=0, rd_valid=0, addr_err=0, init_busy=1 (parity_err=0 when built).
REQ-027 rst asserted mid-sweep or in READY SHALL restart the sweep from word 0; in-flight read results SHALL be discarded.

Configuration
REQ-028 With DP_RAM_PARITY_EN defined, each word SHALL store an extra even-parity bit computed on write (zero words clear to parity 0), and output parity_err (1 bit) SHALL assert with rd_valid when the stored parity mismatches the read data.
REQ-029 Without DP_RAM_PARITY_EN, no parity storage and no parity_err port SHALL exist; all other behaviour identical.

Structure
REQ-030 A shared package dp_ram_pkg SHALL hold the FSM state enum (ST_INIT, ST_READY) and default width/depth constants.
REQ-031 Storage SHALL be one sub-module dp_ram_core (plain one-write/one-read synchronous array); FSM, bypass, range checks and parity live in dp_ram_param.

Verification (DATA_W=8, ADDR_W=8, DEPTH=200)
REQ-032 Release rst -> init_busy high exactly 200 cycles; then read addresses 0, 100, 199 -> data_out 8'h00, rd_valid each one cycle later.
REQ-033 Write 8'hA5 @ 8'h10, next cycle rd_en @ 8'h10 -> data_out 8'hA5, rd_valid=1 one cycle after read; idle cycle -> rd_valid=0, data_out stays 8'hA5.
REQ-034 Same cycle wr 8'h3C @ 8'h20 and rd @ 8'h20 (old 8'h00) -> data_out 8'h3C next cycle.
REQ-035 Write 8'hFF @ 8'd200, read @ 8'd250 -> addr_err pulses one cycle, rd_valid=0; later read @ 8'd199 -> 8'h00.
REQ-036 Assert rst at sweep count 50 -> init_busy stays high, sweep restarts, 200 more cycles; wr_en during INIT -> location still 8'h00 after INIT.
REQ-037 With DP_RAM_PARITY_EN, force stored parity bit of word 8'h05 flipped -> read 8'h05 gives parity_err=1 with rd_valid.
